// File: rtl/dpram_arbiter.sv
// Arbitrates NCLI clients onto one write port and one read port of a dual-port RAM.
// Independent round-robin per port; read responses are routed back via a tag pipeline.
module dpram_arbiter #(
   parameter int NCLI   = 2,
   parameter int AW     = 5,
   parameter int DW     = 8,
   parameter int RD_LAT = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCLI-1:0]      wreq_valid,
   output logic [NCLI-1:0]      wreq_ready,
   input  logic [NCLI*AW-1:0]   wreq_addr,
   input  logic [NCLI*DW-1:0]   wreq_data,
   input  logic [NCLI-1:0]      rreq_valid,
   output logic [NCLI-1:0]      rreq_ready,
   input  logic [NCLI*AW-1:0]   rreq_addr,
   output logic [NCLI-1:0]      rsp_valid,
   output logic [DW-1:0]        rsp_data,
   output logic                 wr_en,
   output logic [AW-1:0]        wr_addr,
   output logic [DW-1:0]        w_data,
   output logic                 rd_en,
   output logic [AW-1:0]        rd_addr,
   input  logic [DW-1:0]        r_data,
   output logic                 busy
);
   localparam int PW = (NCLI > 1) ? $clog2(NCLI) : 1;

   logic [NCLI-1:0][AW-1:0] w_addr_l, r_addr_l;
   logic [NCLI-1:0][DW-1:0] w_data_l;

   for (genvar i = 0; i < NCLI; i++) begin : g_lane
      assign w_addr_l[i] = wreq_addr[i*AW +: AW];
      assign w_data_l[i] = wreq_data[i*DW +: DW];
      assign r_addr_l[i] = rreq_addr[i*AW +: AW];
   end

   // Returns {found, index}; walking k downward lets the lowest offset from ptr win.
   function automatic logic [PW:0] rr_pick(input logic [NCLI-1:0] req, input logic [PW-1:0] ptr);
      logic [PW:0]   r;
      logic [PW-1:0] s;
      int            idx;
      r = '0;
      for (int k = NCLI-1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= NCLI) idx -= NCLI;
         s = PW'(idx);
         if (req[s]) r = {1'b1, s};
      end
      return r;
   endfunction

   function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] g);
      return (g == PW'(NCLI-1)) ? '0 : g + PW'(1);
   endfunction

   logic [PW-1:0] wr_ptr, rd_ptr, w_sel, r_sel;
   logic [PW:0]   w_pick, r_pick;
   logic          w_go, r_go, hazard;

   assign w_pick = rr_pick(wreq_valid, wr_ptr);
   assign r_pick = rr_pick(rreq_valid, rd_ptr);
   assign w_sel  = w_pick[PW-1:0];
   assign r_sel  = r_pick[PW-1:0];
   assign w_go   = w_pick[PW] & ~rst;
   // A read colliding with this cycle's write waits one cycle so it returns the new data.
   assign hazard = w_go && (r_addr_l[r_sel] == w_addr_l[w_sel]);
   assign r_go   = r_pick[PW] & ~rst & ~hazard;

   assign wreq_ready = w_go ? (NCLI'(1) << w_sel) : '0;
   assign rreq_ready = r_go ? (NCLI'(1) << r_sel) : '0;

   logic [RD_LAT:0]           tag_vld;
   logic [RD_LAT:0][PW-1:0]   tag_id;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         w_data    <= '0;
         rd_en     <= 1'b0;
         rd_addr   <= '0;
         tag_vld   <= '0;
         tag_id    <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
      end else begin
         wr_en <= w_go;
         if (w_go) begin
            wr_addr <= w_addr_l[w_sel];
            w_data  <= w_data_l[w_sel];
            wr_ptr  <= rr_next(w_sel);
         end
         rd_en <= r_go;
         if (r_go) begin
            rd_addr <= r_addr_l[r_sel];
            rd_ptr  <= rr_next(r_sel);
         end
         tag_vld[0] <= r_go;
         tag_id[0]  <= r_sel;
         for (int i = 1; i <= RD_LAT; i++) begin
            tag_vld[i] <= tag_vld[i-1];
            tag_id[i]  <= tag_id[i-1];
         end
         // Last tag stage lines up with the cycle r_data is valid.
         rsp_valid <= tag_vld[RD_LAT] ? (NCLI'(1) << tag_id[RD_LAT]) : '0;
         if (tag_vld[RD_LAT]) rsp_data <= r_data;
      end
   end

   assign busy = wr_en | rd_en | (|tag_vld);

endmodule

// File: tb/tb_dpram_arbiter.sv
// Bench for dpram_arbiter: RAM model, reference model of grants/responses, directed and random steps.
module tb_dpram_arbiter;
   localparam int N = 2, AW = 5, DW = 8;

   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]    wv, rv, wr, rr, rspv;
   logic [N*AW-1:0] wa, ra;
   logic [N*DW-1:0] wd;
   logic [DW-1:0]   rspd, w_data;
   logic [DW-1:0]   r_data = '0;
   logic [AW-1:0]   wr_addr, rd_addr;
   logic            wr_en, rd_en, busy;

   dpram_arbiter #(.NCLI(N), .AW(AW), .DW(DW), .RD_LAT(1)) dut (
      .clk(clk), .rst(rst),
      .wreq_valid(wv), .wreq_ready(wr), .wreq_addr(wa), .wreq_data(wd),
      .rreq_valid(rv), .rreq_ready(rr), .rreq_addr(ra),
      .rsp_valid(rspv), .rsp_data(rspd),
      .wr_en(wr_en), .wr_addr(wr_addr), .w_data(w_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .r_data(r_data), .busy(busy));

   // Three-client instance for the pointer wrap case.
   logic [2:0]    w3v, r3v, w3r, r3r, rsp3v;
   logic [14:0]   w3a, r3a;
   logic [23:0]   w3d;
   logic [7:0]    rsp3d, w3data;
   logic [4:0]    w3addr, r3addr;
   logic          w3en, r3en, busy3;
   logic [7:0]    r3data = 8'h5A;

   dpram_arbiter #(.NCLI(3), .AW(AW), .DW(DW), .RD_LAT(1)) u3 (
      .clk(clk), .rst(rst),
      .wreq_valid(w3v), .wreq_ready(w3r), .wreq_addr(w3a), .wreq_data(w3d),
      .rreq_valid(r3v), .rreq_ready(r3r), .rreq_addr(r3a),
      .rsp_valid(rsp3v), .rsp_data(rsp3d),
      .wr_en(w3en), .wr_addr(w3addr), .w_data(w3data),
      .rd_en(r3en), .rd_addr(r3addr), .r_data(r3data), .busy(busy3));

   function automatic logic [7:0] pre(input logic [4:0] a);
      return 8'({3'b0, a} * 8'd7 + 8'd3);
   endfunction

   // RAM: one-cycle read latency, unwritten words read their preload pattern.
   logic [7:0]  ram [32];
   logic [31:0] wrt = '0;
   always @(posedge clk) begin
      if (wr_en) begin ram[wr_addr] <= w_data; wrt[wr_addr] <= 1'b1; end
      if (rd_en) r_data <= wrt[rd_addr] ? ram[rd_addr] : pre(rd_addr);
   end

   typedef struct { int due; int cli; logic [7:0] data; } rsp_t;
   rsp_t        q[$];
   logic [7:0]  m_mem [32];
   int          total = 0, bad = 0, cyc = 0, m_wptr = 0, m_rptr = 0;
   logic        e_wr_en = 0, e_rd_en = 0;
   logic [4:0]  e_wr_addr = '0, e_rd_addr = '0;
   logic [7:0]  e_w_data = '0, e_rsp_data = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_wptr = 0; m_rptr = 0; q.delete();
      e_wr_en = 0; e_rd_en = 0; e_rsp_data = '0;
   endtask

   // Called just after a negedge with inputs already applied; returns at the next negedge.
   task automatic step();
      int wg, rc, rg;
      logic [N-1:0] ew, er, erv;
      #1;
      wg = -1; rc = -1;
      for (int k = 0; k < N; k++) begin
         int i;
         i = (m_wptr + k) % N;
         if (wg < 0 && wv[i]) wg = i;
         i = (m_rptr + k) % N;
         if (rc < 0 && rv[i]) rc = i;
      end
      rg = rc;
      if (rc >= 0 && wg >= 0 && ra[rc*AW +: AW] == wa[wg*AW +: AW]) rg = -1;
      ew = (wg >= 0) ? N'(1) << wg : '0;
      er = (rg >= 0) ? N'(1) << rg : '0;
      chk("wreq_ready", 32'(wr), 32'(ew));
      chk("rreq_ready", 32'(rr), 32'(er));
      e_rd_en = (rg >= 0);
      if (rg >= 0) begin
         e_rd_addr = ra[rg*AW +: AW];
         q.push_back('{cyc + 3, rg, m_mem[e_rd_addr]});
         m_rptr = (rg + 1) % N;
      end
      e_wr_en = (wg >= 0);
      if (wg >= 0) begin
         e_wr_addr = wa[wg*AW +: AW];
         e_w_data  = wd[wg*DW +: DW];
         m_mem[e_wr_addr] = e_w_data;
         m_wptr = (wg + 1) % N;
      end
      @(posedge clk); #1; cyc++;
      chk("wr_en", 32'(wr_en), 32'(e_wr_en));
      chk("rd_en", 32'(rd_en), 32'(e_rd_en));
      if (e_wr_en) begin
         chk("wr_addr", 32'(wr_addr), 32'(e_wr_addr));
         chk("w_data", 32'(w_data), 32'(e_w_data));
      end
      if (e_rd_en) chk("rd_addr", 32'(rd_addr), 32'(e_rd_addr));
      erv = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
         erv = N'(1) << q[0].cli;
         e_rsp_data = q[0].data;
         void'(q.pop_front());
      end
      chk("rsp_valid", 32'(rspv), 32'(erv));
      chk("rsp_data", 32'(rspd), 32'(e_rsp_data));
      chk("busy", 32'(busy), 32'(e_wr_en || q.size() != 0));
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) m_mem[i] = pre(5'(i));
      wv = '0; rv = '0; wa = '0; wd = '0; ra = '0;
      w3v = '0; r3v = '0; w3a = '0; w3d = '0; r3a = '0;
      #12 rst = 1'b0;
      @(negedge clk);
      chk("rst_wr_en", 32'(wr_en), 0);
      chk("rst_rd_en", 32'(rd_en), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rsp_valid", 32'(rspv), 0);
      chk("rst_rsp_data", 32'(rspd), 0);

      // single write then read back
      wv = 2'b10; wa[5 +: 5] = 5'd5; wd[8 +: 8] = 8'hA5;
      step();
      chk("t2_wr_addr", 32'(wr_addr), 5);
      chk("t2_w_data", 32'(w_data), 32'h A5);
      wv = '0;
      step(); step();
      rv = 2'b10; ra[5 +: 5] = 5'd5;
      step();
      rv = '0;
      step(); step();
      chk("t2_rsp_valid", 32'(rspv), 2);
      chk("t2_rsp_data", 32'(rspd), 32'h A5);

      // round-robin alternation
      wv = 2'b11; wa = {5'd2, 5'd1}; wd = 16'h1234;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("t3_wr_addr", 32'(wr_addr), (k % 2) ? 2 : 1);
      end
      wv = '0;
      step();

      // write/read address hazard
      wv = 2'b01; wa[0 +: 5] = 5'd7; wd[0 +: 8] = 8'h3C;
      rv = 2'b10; ra[5 +: 5] = 5'd7;
      step();
      chk("t4_rd_deferred", 32'(rd_en), 0);
      wv = '0;
      step();
      rv = '0;
      step(); step();
      chk("t4_rsp_valid", 32'(rspv), 2);
      chk("t4_rsp_data", 32'(rspd), 32'h3C);

      // back-to-back alternating reads
      for (int k = 0; k < 8; k++) begin
         rv = (k % 2) ? 2'b10 : 2'b01;
         ra = {5'(k), 5'(k)};
         step();
         chk("t5_busy", 32'(busy), 1);
      end
      rv = '0;
      step(); step();
      chk("t5_busy_low", 32'(busy), 0);
      step(); step();

      // asynchronous reset with a read in flight
      rv = 2'b01; ra[0 +: 5] = 5'd3;
      step();
      wv = 2'b11; wa = {5'd9, 5'd8}; rv = 2'b11; ra = {5'd4, 5'd3};
      #2 rst = 1'b1;
      #1;
      chk("ar_wreq_ready", 32'(wr), 0);
      chk("ar_rreq_ready", 32'(rr), 0);
      chk("ar_rd_en", 32'(rd_en), 0);
      chk("ar_busy", 32'(busy), 0);
      chk("ar_rsp_data", 32'(rspd), 0);
      wv = '0; rv = '0;
      @(posedge clk); #2 rst = 1'b0;
      model_reset();
      @(negedge clk);
      for (int k = 0; k < 4; k++) step();
      wv = 2'b11; rv = 2'b11;
      step();
      chk("ar_ptr_w0", 32'(wr_addr), 8);
      wv = '0; rv = '0;
      for (int k = 0; k < 4; k++) step();

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         wv = 2'($urandom); rv = 2'($urandom);
         wd = 16'($urandom);
         for (int c = 0; c < N; c++) begin
            wa[c*AW +: AW] = 5'($urandom_range(0, 7));
            ra[c*AW +: AW] = 5'($urandom_range(0, 7));
         end
         step();
      end
      wv = '0; rv = '0;
      for (int k = 0; k < 4; k++) step();

      // three clients: pointer wraps from client 2 to client 0
      w3a = '0; r3a = {5'd1, 5'd1, 5'd1};
      w3v = 3'b100; r3v = 3'b100;
      #1;
      chk("w3_grant_c2", 32'(w3r), 4);
      chk("r3_grant_c2", 32'(r3r), 4);
      @(negedge clk);
      w3v = 3'b011; r3v = 3'b011;
      #1;
      chk("w3_grant_c0", 32'(w3r), 1);
      chk("r3_grant_c0", 32'(r3r), 1);
      @(negedge clk);
      w3v = '0; r3v = '0;
      @(negedge clk);
      chk("r3_rsp_c2", 32'(rsp3v), 4);
      chk("r3_rsp_data", 32'(rsp3d), 32'h5A);
      @(negedge clk);
      chk("r3_rsp_c0", 32'(rsp3v), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/dpram_arbiter.md
Name: dpram_arbiter

Overview:
Shares the single-write/single-read dual-port RAM (32 x 8) between NCLI requesting clients. The write port and the read port are arbitrated independently, each with its own round-robin pointer. The block tracks outstanding reads and routes each read response back to the client that issued it. It sits between the client agents and the RAM pins: wr_en, rd_en, wr_addr, rd_addr, w_data, r_data.

Parameters:
NCLI, 2, number of requesting clients (2..4)
AW, 5, RAM address width
DW, 8, RAM data width
RD_LAT, 1, RAM read latency: cycles from the sampling edge of rd_en until r_data is valid

Ports:
clk  input  1  single clock; all state updates on posedge
rst  input  1  asynchronous active-high reset
wreq_valid  input  NCLI  per-client write request
wreq_ready  output  NCLI  per-client write grant (combinational)
wreq_addr  input  NCLI*AW  per-client write address, client i at [i*AW +: AW]
wreq_data  input  NCLI*DW  per-client write data, client i at [i*DW +: DW]
rreq_valid  input  NCLI  per-client read request
rreq_ready  output  NCLI  per-client read grant (combinational)
rreq_addr  input  NCLI*AW  per-client read address
rsp_valid  output  NCLI  one-hot read response strobe
rsp_data  output  DW  read data, qualified by rsp_valid
wr_en  output  1  RAM write enable (registered)
wr_addr  output  AW  RAM write address (registered)
w_data  output  DW  RAM write data (registered)
rd_en  output  1  RAM read enable (registered)
rd_addr  output  AW  RAM read address (registered)
r_data  input  DW  RAM read data
busy  output  1  high while any read is in flight or a RAM enable is high

Behaviour:
- Reset values: all outputs 0. Round-robin pointers wr_ptr and rd_ptr = 0. Read-tag pipeline cleared. Reset mid-operation drops in-flight reads; no rsp_valid is produced for them.
- Handshake: a transfer occurs in a cycle where valid&ready are both high for a client. At most one write transfer and one read transfer occur per cycle.
- Ready is never asserted without valid. A client may change its request after a transfer, or withdraw an unserved request.
- Write arbitration: scan clients starting at wr_ptr, wrapping modulo NCLI. The first one with wreq_valid is granted. After a grant to client g, wr_ptr <= (g+1) mod NCLI. With no grant, wr_ptr holds.
- Read arbitration uses the same rule with rd_ptr. Candidate = the first valid client found from rd_ptr.
- Write/read address hazard: if a write is granted this cycle and the read candidate's address equals the granted write address, no read is granted this cycle. rd_ptr holds. The candidate retries next cycle, so it observes the new data.
- Write timing: handshake in cycle C -> wr_en=1 with wr_addr/w_data during cycle C+1. wr_en=0 in any cycle following a cycle with no write grant.
- Read timing: handshake in cycle C -> rd_en=1 with rd_addr during C+1 -> r_data valid in C+1+RD_LAT.
- Read response: r_data is captured at the end of cycle C+1+RD_LAT. rsp_valid[client]=1 and rsp_data are driven in cycle C+2+RD_LAT for exactly 1 cycle. With RD_LAT=1, that is 3 cycles after the handshake.
- Client-ID routing: a tag shift pipeline of depth RD_LAT+1 carries {valid, client_id}. Responses return in issue order. Reads may be issued back-to-back every cycle.
- Responses have no backpressure. Clients must accept rsp_valid when it arrives.
- rsp_data holds its last value when rsp_valid=0.
- Simultaneous write and read from the same client are allowed and arbitrated independently, subject to the hazard rule.
- busy = wr_en | rd_en | any valid tag in the pipeline.

Test Plan:
1. Reset: assert rst asynchronously mid-cycle with client 0 read in flight -> all outputs 0 immediately; no rsp_valid after rst falls; wr_ptr=rd_ptr=0.
2. Single write/read: client 1 writes addr 5, data 0xA5 at cycle C -> wr_en=1, wr_addr=5, w_data=0xA5 in C+1. Client 1 reads addr 5 at C+3 -> rd_en in C+4; rsp_valid=2'b10, rsp_data=0xA5 in C+6.
3. Round-robin: both clients hold wreq_valid for 4 cycles, client 0 writing addr 1 and client 1 writing addr 2 -> grants alternate 0,1,0,1; wr_addr sequence 1,2,1,2.
4. Hazard: client 0 writes addr 7 = 0x3C while client 1 reads addr 7 in the same cycle -> read deferred 1 cycle; response data = 0x3C (new value).
5. Back-to-back reads: clients alternate reads of addrs 0..7, one per cycle, 8 cycles -> rsp_valid one-hot alternates each cycle; data matches preload; busy=1 throughout, then 0 three cycles after the last grant.
6. Wrap-around: NCLI=3, only client 2 requests, then client 0 requests -> grant to client 2, then wr_ptr=0 and client 0 is granted on its first request.
